// File: rtl/vector_memory_arbiter.sv
// Arbitrates the single-port vector data memory between the CPU M-stage and a host burst loader.
// The CPU normally wins; a saturating wait counter forces one host slot after MAX_WAIT denials.
module vector_memory_arbiter #(
    parameter int DATA_WIDTH    = 96,
    parameter int ADDRESS_WIDTH = 16,
    parameter int LEN_WIDTH     = 8,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuReq,
    input  logic                     cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    input  logic [DATA_WIDTH-1:0]    cpuWriteData,
    output logic [DATA_WIDTH-1:0]    cpuReadData,
    output logic                     cpuStall,
    input  logic                     hostStart,
    input  logic                     hostWrite,
    input  logic [ADDRESS_WIDTH-1:0] hostBase,
    input  logic [LEN_WIDTH-1:0]     hostLength,
    input  logic [DATA_WIDTH-1:0]    hostWriteData,
    input  logic                     hostWriteValid,
    output logic                     hostWriteReady,
    output logic [DATA_WIDTH-1:0]    hostReadData,
    output logic                     hostReadValid,
    output logic                     hostBusy,
    output logic                     hostDone,
    output logic                     memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0]    memWriteData,
    input  logic [DATA_WIDTH-1:0]    memReadData
);

    localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [LEN_WIDTH-1:0]     index;
    logic [LEN_WIDTH-1:0]     burst_len;
    logic [ADDRESS_WIDTH-1:0] burst_base;
    logic                     burst_write;
    logic [WAIT_WIDTH-1:0]    wait_count;
    logic                     read_valid;
    logic                     host_pending;
    logic                     host_grant;
    logic [ADDRESS_WIDTH-1:0] host_address;

    // Address sum wraps naturally at the memory address width.
    assign host_address = burst_base + ADDRESS_WIDTH'(index);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        host_pending   = 1'b0;
        host_grant     = 1'b0;
        memWriteEnable = cpuReq & cpuWrite;
        memAddress     = cpuAddress;
        memWriteData   = cpuWriteData;
        hostWriteReady = 1'b0;
        case (state)
            IDLE: begin
                if (hostStart) begin
                    state_next = (hostLength == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                host_pending = burst_write ? hostWriteValid : 1'b1;
                host_grant   = host_pending &&
                               (!cpuReq || wait_count == WAIT_WIDTH'(MAX_WAIT));
                if (host_grant) begin
                    memAddress     = host_address;
                    memWriteData   = hostWriteData;
                    memWriteEnable = burst_write;
                    hostWriteReady = burst_write;
                    if (index == burst_len - LEN_WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cpuStall      = cpuReq & host_grant;
    assign cpuReadData   = memReadData;
    assign hostBusy      = (state != IDLE);
    assign hostDone      = (state == DONE);
    assign hostReadValid = read_valid;
    assign hostReadData  = read_valid ? memReadData : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            index       <= '0;
            burst_len   <= '0;
            burst_base  <= '0;
            burst_write <= 1'b0;
            wait_count  <= '0;
            read_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            read_valid <= host_grant & ~burst_write;
            if (state == IDLE && hostStart) begin
                burst_base  <= hostBase;
                burst_len   <= hostLength;
                burst_write <= hostWrite;
                index       <= '0;
            end else if (host_grant) begin
                index <= index + LEN_WIDTH'(1);
            end
            if (state != BURST || host_grant) begin
                wait_count <= '0;
            end else if (host_pending && wait_count != WAIT_WIDTH'(MAX_WAIT)) begin
                wait_count <= wait_count + WAIT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Directed, table-driven bench for vector_memory_arbiter with a 1-cycle-latency memory model.
// Each vector drives one cycle of inputs and checks the outputs mid-cycle on the falling edge.
module tb_vector_memory_arbiter;

    localparam int DW = 96;
    localparam int AW = 16;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpuReq = 1'b0;
    logic          cpuWrite = 1'b0;
    logic [AW-1:0] cpuAddress = '0;
    logic [DW-1:0] cpuWriteData = '0;
    logic [DW-1:0] cpuReadData;
    logic          cpuStall;
    logic          hostStart = 1'b0;
    logic          hostWrite = 1'b0;
    logic [AW-1:0] hostBase = '0;
    logic [LW-1:0] hostLength = '0;
    logic [DW-1:0] hostWriteData = '0;
    logic          hostWriteValid = 1'b0;
    logic          hostWriteReady;
    logic [DW-1:0] hostReadData;
    logic          hostReadValid;
    logic          hostBusy;
    logic          hostDone;
    logic          memWriteEnable;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memWriteData;
    logic [DW-1:0] memReadData = '0;

    logic [DW-1:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    vector_memory_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW), .MAX_WAIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
        .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .cpuStall(cpuStall),
        .hostStart(hostStart), .hostWrite(hostWrite), .hostBase(hostBase),
        .hostLength(hostLength), .hostWriteData(hostWriteData),
        .hostWriteValid(hostWriteValid), .hostWriteReady(hostWriteReady),
        .hostReadData(hostReadData), .hostReadValid(hostReadValid),
        .hostBusy(hostBusy), .hostDone(hostDone),
        .memWriteEnable(memWriteEnable), .memAddress(memAddress),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    always #5 clock = ~clock;

    // Single-port memory: write on enable, registered read of the presented address.
    always @(posedge clock) begin
        if (memWriteEnable) mem[memAddress] <= memWriteData;
        memReadData <= mem[memAddress];
    end

    typedef struct {
        logic          rst;
        logic          cq;
        logic          cw;
        logic [15:0]   ca;
        logic          hs;
        logic          hw;
        logic [15:0]   hb;
        logic [7:0]    hl;
        logic          hv;
        logic [15:0]   wd;
        logic [5:0]    e_flags;   // {we, stall, busy, done, wready, rvalid}
        logic [15:0]   e_addr;
        logic [15:0]   e_wd;
        logic [15:0]   e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, cq, cw, input logic [15:0] ca,
                               input logic hs, hw, input logic [15:0] hb,
                               input logic [7:0] hl, input logic hv, input logic [15:0] wd,
                               input logic [5:0] e_flags, input logic [15:0] e_addr,
                               input logic [15:0] e_wd, input logic [15:0] e_rd);
        vec_t t;
        t.rst = rst; t.cq = cq; t.cw = cw; t.ca = ca;
        t.hs = hs; t.hw = hw; t.hb = hb; t.hl = hl; t.hv = hv; t.wd = wd;
        t.e_flags = e_flags; t.e_addr = e_addr; t.e_wd = e_wd; t.e_rd = e_rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host data is the 16-bit tag replicated per lane; CPU data is its complement.
    task automatic run_vec(input vec_t t, input string tag, input bit do_check);
        @(posedge clock);
        #1;
        reset          = t.rst;
        cpuReq         = t.cq;
        cpuWrite       = t.cw;
        cpuAddress     = t.ca;
        cpuWriteData   = {6{~t.wd}};
        hostStart      = t.hs;
        hostWrite      = t.hw;
        hostBase       = t.hb;
        hostLength     = t.hl;
        hostWriteValid = t.hv;
        hostWriteData  = {6{t.wd}};
        @(negedge clock);
        if (do_check) begin
            check({tag, " ctl"},
                  {106'b0, memWriteEnable, cpuStall, hostBusy, hostDone,
                   hostWriteReady, hostReadValid, memAddress},
                  {106'b0, t.e_flags, t.e_addr});
            if (t.e_flags[5]) check({tag, " wdata"}, memWriteData, {6{t.e_wd}});
            if (t.e_flags[0]) check({tag, " rdata"}, hostReadData, {6{t.e_rd}});
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = '0;

        // reset state
        tbl.push_back(v(1,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        // host write burst base 0x10 len 3, CPU idle
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0010,3,1,16'h0001, 6'b000000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h0001, 6'b101010,16'h0010,16'h0001,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h0002, 6'b101010,16'h0011,16'h0002,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h0003, 6'b101010,16'h0012,16'h0003,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001100,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        // host read burst len 2 of the data just written
        tbl.push_back(v(0,0,0,16'h0000, 1,0,16'h0010,2,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001000,16'h0010,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001001,16'h0011,16'h0000,16'h1));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001101,16'h0000,16'h0000,16'h2));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        // CPU held busy during a write burst: 4 CPU wins then one forced host slot
        tbl.push_back(v(0,1,1,16'h0100, 1,1,16'h0020,4,1,16'h0000, 6'b100000,16'h0100,16'hFFFF,16'h0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                tbl.push_back(v(0,1,1,16'h0100, 0,0,16'h0000,0,1,16'h0000, 6'b101000,16'h0100,16'hFFFF,16'h0));
            tbl.push_back(v(0,1,1,16'h0100, 0,0,16'h0000,0,1,16'h0055 + 16'(r * 16'h11),
                            6'b111010,16'h0020 + 16'(r),16'h0055 + 16'(r * 16'h11),16'h0));
        end
        tbl.push_back(v(0,0,0,16'h0100, 0,0,16'h0000,0,0,16'h0000, 6'b001000,16'h0100,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0100, 0,0,16'h0000,0,1,16'h0077, 6'b101010,16'h0022,16'h0077,16'h0));
        tbl.push_back(v(0,0,0,16'h0100, 0,0,16'h0000,0,1,16'h0088, 6'b101010,16'h0023,16'h0088,16'h0));
        tbl.push_back(v(0,0,0,16'h0100, 0,0,16'h0000,0,0,16'h0000, 6'b001100,16'h0100,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0100, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0100,16'h0000,16'h0));
        // address wrap: base 0xFFFF len 2
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'hFFFF,2,1,16'h00AA, 6'b000000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00AA, 6'b101010,16'hFFFF,16'h00AA,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00BB, 6'b101010,16'h0000,16'h00BB,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001100,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        // zero length: straight to DONE with no memory write
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0050,0,1,16'h00CC, 6'b000000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00CC, 6'b001100,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        // hostStart during BURST is ignored; original base, length and direction persist
        tbl.push_back(v(0,0,0,16'h0000, 1,1,16'h0060,2,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 1,0,16'h0040,5,0,16'h0000, 6'b001000,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00D1, 6'b101010,16'h0060,16'h00D1,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00D2, 6'b101010,16'h0061,16'h00D2,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b001100,16'h0000,16'h0000,16'h0));
        tbl.push_back(v(0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000, 6'b000000,16'h0000,16'h0000,16'h0));

        repeat (2) @(posedge clock);
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b1);

        // Reset mid-burst at index 1 of 4: burst aborts, CPU proceeds unstalled.
        run_vec(v(0,0,0,16'h0000, 1,1,16'h0030,4,1,16'h00E1, 6'b000000,16'h0000,16'h0000,16'h0), "abort start", 1'b1);
        run_vec(v(0,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00E1, 6'b101010,16'h0030,16'h00E1,16'h0), "abort beat0", 1'b1);
        run_vec(v(1,0,0,16'h0000, 0,0,16'h0000,0,1,16'h00E2, 6'b000000,16'h0000,16'h0000,16'h0), "abort reset", 1'b0);
        run_vec(v(0,1,1,16'h0200, 0,0,16'h0000,0,1,16'h00F0, 6'b100000,16'h0200,16'hFF0F,16'h0), "abort cpu", 1'b1);
        for (int k = 0; k < 3; k++)
            run_vec(v(0,0,0,16'h0200, 0,0,16'h0000,0,1,16'h00F1, 6'b000000,16'h0200,16'h0000,16'h0),
                    $sformatf("abort idle%0d", k), 1'b1);

        // Memory contents left behind by the bursts and CPU accesses.
        check("mem 0010", mem[16'h0010], {6{16'h0001}});
        check("mem 0012", mem[16'h0012], {6{16'h0003}});
        check("mem 0020", mem[16'h0020], {6{16'h0055}});
        check("mem 0021", mem[16'h0021], {6{16'h0066}});
        check("mem 0023", mem[16'h0023], {6{16'h0088}});
        check("mem 0100", mem[16'h0100], {6{16'hFFFF}});
        check("mem FFFF", mem[16'hFFFF], {6{16'h00AA}});
        check("mem 0000", mem[16'h0000], {6{16'h00BB}});
        check("mem 0050", mem[16'h0050], {DW{1'b0}});
        check("mem 0040", mem[16'h0040], {DW{1'b0}});
        check("mem 0061", mem[16'h0061], {6{16'h00D2}});
        check("mem 0030", mem[16'h0030], {6{16'h00E1}});
        check("mem 0032", mem[16'h0032], {DW{1'b0}});
        check("mem 0200", mem[16'h0200], {6{16'hFF0F}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
